pktd_mem_arbiter: RTL and testbench
===================================

# pktd_mem_arbiter

Round-robin arbiter that shares one single-port, synchronous-read packet-buffer SRAM between up to four packet-FIFO requesters (e.g. TX DMA FIFO, RX DMA FIFO). It replaces direct FIFO-to-memory wiring so that one physical buffer serves all channels. It adds a lock/burst mechanism so a requester can stream a packet without interleaving, bounded by a maximum burst length. The memory command is registered and read data returns with fixed latency.

## Interface
- DWIDTH, 64, data word width
- AWIDTH, 8, buffer address width
- NREQ, 2, number of requesters (legal 2..4)
- MAXBURST, 16, max consecutive locked grants to one owner while another requester waits (legal 2..255)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester access request, held until granted
- lock  in  NREQ  per-requester burst hold, sampled with req
- we  in  NREQ  1 = write, 0 = read
- addr  in  NREQ*AWIDTH  packed addresses, requester i at [i*AWIDTH +: AWIDTH]
- wdata  in  NREQ*DWIDTH  packed write data
- gnt  out  NREQ  one-hot grant, combinational, same cycle as accepted req
- rvalid  out  NREQ  one-hot read-return strobe
- rdata  out  DWIDTH  read data, valid only where rvalid is set
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AWIDTH  memory address
- mem_wdata  out  DWIDTH  memory write data
- mem_rdata  in  DWIDTH  memory read data, valid one cycle after mem_en with mem_we=0

## Operation
- At most one gnt bit per cycle. A granted access is accepted: no retry.
- Pick order: round-robin. Search starts at last_gnt+1 mod NREQ. Reset value of last_gnt is NREQ-1, so requester 0 wins first.
- FSM state ARB (no owner):
  - Grant per round-robin.
  - If the winner also has lock=1, go to OWN with owner=winner and burst_cnt=1.
- FSM state OWN:
  - Owner has absolute priority while req[owner]&lock[owner]. Each grant does burst_cnt+1, saturating at MAXBURST.
  - Owner drops req or lock: return to ARB. The same cycle is arbitrated round-robin, so the owner may still win a plain request.
  - burst_cnt==MAXBURST and any other req pending: forced rotation. Owner is excluded that cycle, the round-robin winner among the others is granted, and the FSM goes to ARB (or OWN with the new owner if it locks).
  - burst_cnt==MAXBURST and no other req pending: owner keeps grant and the count holds.
- Reads and writes are serviced in grant order, so read-after-write to the same address returns new data.
- Reset values: gnt=0 (combinational, forced 0 during rst), rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, state=ARB, burst_cnt=0.
- Reset mid-operation clears the command register and the read-return pipe. In-flight reads never return.

## Timing
- Cycle T: req[i]=1 → gnt[i]=1 in T if selected. Requester holds addr/we/wdata valid in T only.
- T+1: mem_en=1, mem_we, mem_addr and mem_wdata registered from T.
- T+2 (reads): rvalid[i]=1, rdata=mem_rdata. Read latency is 2 cycles from grant.
- Throughput is one access per cycle, back-to-back, any mix of requesters.
- rdata is driven 0 when no rvalid is set.
- Address arithmetic is none beyond selection. Address wrap is the FIFO's responsibility.

## Structure
- Package pktd_arb_pkg: state enum (ARB, OWN), constants for default widths, a function for burst counter width clog2(MAXBURST+1).
- Sub-module rr_pick: parameter NREQ; inputs req vector, exclude mask, last index; outputs one-hot pick and valid.
- Top contains the FSM, burst counter, command register, and the 2-deep one-hot rvalid shift pipe.

## Test plan
- Single read: req[0], we=0, addr=0x05 at T, memory preloaded 0x05→0xA5A5 → gnt[0] at T, mem_en/addr=0x05 at T+1, rvalid[0], rdata=0xA5A5 at T+2.
- Contention without lock: req[0] and req[1] continuous for 6 cycles after reset → grants 0,1,0,1,0,1.
- Locked burst, MAXBURST=4: req0+lock0 held, req1 pending from the start → gnt0 ×4, then gnt1 ×1, then gnt0 resumes with burst_cnt=1.
- Lock with no competitor: req0+lock0 for 20 cycles, req1 low → gnt0 every cycle, burst_cnt stays at 4, no gaps.
- RAW ordering: req0 write addr 0x10 data 0x1234 at T, req1 read addr 0x10 at T+1 → rvalid[1] at T+3 with rdata=0x1234.
- Reset mid-read: read granted at T, rst pulsed at T+1 → rvalid stays 0 throughout, and after release the first grant goes to requester 0.

Source files
------------

// File: rtl/pktd_arb_pkg.sv
// Shared types and constants for the packet-buffer memory arbiter.
package pktd_arb_pkg;

  typedef enum logic {StArb, StOwn} arb_state_e;

  localparam int unsigned DefDwidth   = 64;
  localparam int unsigned DefAwidth   = 8;
  localparam int unsigned DefNreq     = 2;
  localparam int unsigned DefMaxburst = 16;

  function automatic int unsigned burst_cnt_width(input int unsigned maxburst);
    return $clog2(maxburst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester after last_i (wrapping) that is not excluded.
module rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] excl_i,
  input  logic [IdxW-1:0] last_i,
  output logic [NREQ-1:0] pick_o,
  output logic            valid_o
);

  logic [NREQ-1:0] cand;
  logic [IdxW-1:0] idx;

  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = '0;
    cand    = req_i & ~excl_i;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IdxW'((int'(last_i) + k) % NREQ);
      if (!valid_o && cand[idx]) begin
        pick_o[idx] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pktd_mem_arbiter.sv
// Shares one synchronous-read packet-buffer SRAM between NREQ FIFO requesters with
// round-robin arbitration, bounded lock bursts, a registered command and 2-cycle read return.
module pktd_mem_arbiter
  import pktd_arb_pkg::*;
#(
  parameter int unsigned DWIDTH   = DefDwidth,
  parameter int unsigned AWIDTH   = DefAwidth,
  parameter int unsigned NREQ     = DefNreq,
  parameter int unsigned MAXBURST = DefMaxburst
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0]          lock_i,
  input  logic [NREQ-1:0]          we_i,
  input  logic [NREQ*AWIDTH-1:0]   addr_i,
  input  logic [NREQ*DWIDTH-1:0]   wdata_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [NREQ-1:0]          rvalid_o,
  output logic [DWIDTH-1:0]        rdata_o,
  output logic                     mem_en_o,
  output logic                     mem_we_o,
  output logic [AWIDTH-1:0]        mem_addr_o,
  output logic [DWIDTH-1:0]        mem_wdata_o,
  input  logic [DWIDTH-1:0]        mem_rdata_i
);

  localparam int unsigned IdxW    = $clog2(NREQ);
  localparam int unsigned CntW    = burst_cnt_width(MAXBURST);
  localparam logic [CntW-1:0] CntMax  = CntW'(MAXBURST);
  localparam logic [IdxW-1:0] LastRst = IdxW'(NREQ - 1);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] last_q, last_d;

  logic [NREQ-1:0] owner_mask, excl, pick, gnt;
  logic            pick_valid, own_hold, others_pend, at_max, force_rot, owner_grant;
  logic            any_gnt, sel_we, sel_lock;
  logic [IdxW-1:0] win_idx;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;

  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [NREQ-1:0]   rd_pend_q, rd_pend_d, rvalid_q;

  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    own_hold    = (state_q == StOwn) && req_i[owner_q] && lock_i[owner_q];
    others_pend = |(req_i & ~owner_mask);
    at_max      = (cnt_q == CntMax);
    // Burst exhausted with a waiter: the owner sits out this one cycle.
    force_rot   = own_hold && at_max && others_pend;
    owner_grant = own_hold && !force_rot;
    excl        = force_rot ? owner_mask : '0;
  end

  rr_pick #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req_i   (req_i),
    .excl_i  (excl),
    .last_i  (last_q),
    .pick_o  (pick),
    .valid_o (pick_valid)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StArb;
      owner_q <= '0;
      cnt_q   <= '0;
      last_q  <= LastRst;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Output logic: grant and the selected requester's command fields
  always_comb begin
    gnt = '0;
    if (!rst_i) begin
      gnt = owner_grant ? owner_mask : (pick_valid ? pick : '0);
    end
    any_gnt   = |gnt;
    win_idx   = '0;
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_idx   = IdxW'(i);
        sel_we    = we_i[i];
        sel_lock  = lock_i[i];
        sel_addr  = addr_i[i*AWIDTH +: AWIDTH];
        sel_wdata = wdata_i[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign gnt_o = gnt;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    last_d  = any_gnt ? win_idx : last_q;
    if (owner_grant) begin
      state_d = StOwn;
      if (!at_max) cnt_d = cnt_q + CntW'(1);
    end else if (any_gnt && sel_lock) begin
      state_d = StOwn;
      owner_d = win_idx;
      cnt_d   = CntW'(1);
    end else begin
      state_d = StArb;
      cnt_d   = '0;
    end
  end

  always_comb begin
    mem_en_d    = any_gnt;
    mem_we_d    = any_gnt && sel_we;
    mem_addr_d  = any_gnt ? sel_addr : mem_addr_q;
    mem_wdata_d = any_gnt ? sel_wdata : mem_wdata_q;
    rd_pend_d   = gnt & ~we_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pend_q   <= '0;
      rvalid_q    <= '0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pend_q   <= rd_pend_d;
      rvalid_q    <= rd_pend_q;
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rvalid_o    = rvalid_q;
  // SRAM read data lands in the same cycle the return strobe is raised.
  assign rdata_o     = (|rvalid_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_pktd_mem_arbiter.sv
// Self-checking bench for pktd_mem_arbiter: directed scenarios plus randomized traffic
// against a grant/streak model and a shadow copy of the buffer memory.
module tb_pktd_mem_arbiter;

  localparam int NR = 3;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int MAXB = 4;

  logic clk, rst;
  logic [NR-1:0] req, lock, we, gnt, rvalid;
  logic [NR*AW-1:0] addr;
  logic [NR*DW-1:0] wdata;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] smem [256];
  logic pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  int n_checks, n_pass;
  int m_last, m_owner, m_cnt;

  pktd_mem_arbiter #(
    .DWIDTH   (DW),
    .AWIDTH   (AW),
    .NREQ     (NR),
    .MAXBURST (MAXB)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .lock_i      (lock),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous-read SRAM with a bench-side preload path.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic idle();
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; idle();
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk); pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk); pl_en = 1'b0;
  endtask

  function automatic int rr_choose(input logic [NR-1:0] m);
    int idx;
    for (int k = 1; k <= NR; k++) begin
      idx = (m_last + k) % NR;
      if (m[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // Grant model: owner keeps winning while it locks, until it has had MAXB grants and
  // someone else is waiting; otherwise plain round robin after the last winner.
  task automatic model_step(input logic [NR-1:0] r, input logic [NR-1:0] l, output int g);
    logic [NR-1:0] others;
    bit hold;
    g = -1;
    hold = (m_owner >= 0) && r[m_owner[1:0]] && l[m_owner[1:0]];
    others = r;
    if (m_owner >= 0) others[m_owner[1:0]] = 1'b0;
    if (hold && (m_cnt < MAXB || others == '0)) begin
      g = m_owner;
      if (m_cnt < MAXB) m_cnt++;
      m_last = g;
    end else begin
      g = hold ? rr_choose(others) : rr_choose(r);
      if (g >= 0) begin
        m_last = g;
        if (l[g[1:0]]) begin m_owner = g; m_cnt = 1; end
        else m_owner = -1;
      end else m_owner = -1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; req = '1; lock = '1;
    #1;
    n_checks++; if (gnt !== 3'b000) $display("FAIL rst_gnt: got %b want 000", gnt); else n_pass++;
    n_checks++; if (mem_en !== 1'b0) $display("FAIL rst_mem_en: got %b want 0", mem_en); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 8'h00) $display("FAIL rst_mem_addr: got %h want 00", mem_addr);
    else n_pass++;
    n_checks++; if (mem_wdata !== 64'h0) $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata);
    else n_pass++;
    n_checks++; if (rvalid !== 3'b000) $display("FAIL rst_rvalid: got %b want 000", rvalid);
    else n_pass++;
    n_checks++; if (rdata !== 64'h0) $display("FAIL rst_rdata: got %h want 0", rdata); else n_pass++;
    @(negedge clk); rst = 1'b0; idle();
  endtask

  task automatic test_single_read();
    preload(8'h05, 64'hA5A5);
    @(negedge clk); req = 3'b001; we = 3'b000; addr[0 +: AW] = 8'h05; #1;
    n_checks++; if (gnt !== 3'b001) $display("FAIL sr_gnt: got %b want 001", gnt); else n_pass++;
    @(negedge clk); idle(); #1;
    n_checks++; if (mem_en !== 1'b1) $display("FAIL sr_mem_en: got %b want 1", mem_en); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL sr_mem_we: got %b want 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 8'h05) $display("FAIL sr_mem_addr: got %h want 05", mem_addr);
    else n_pass++;
    n_checks++; if (rvalid !== 3'b000) $display("FAIL sr_rvalid_t1: got %b want 000", rvalid);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (rvalid !== 3'b001) $display("FAIL sr_rvalid: got %b want 001", rvalid);
    else n_pass++;
    n_checks++; if (rdata !== 64'hA5A5) $display("FAIL sr_rdata: got %h want a5a5", rdata);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (rvalid !== 3'b000) $display("FAIL sr_rvalid_off: got %b want 000", rvalid);
    else n_pass++;
    n_checks++; if (rdata !== 64'h0) $display("FAIL sr_rdata_off: got %h want 0", rdata); else n_pass++;
  endtask

  task automatic test_contention();
    logic [NR-1:0] exp;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); req = 3'b011; we = '0; #1;
      exp = (i % 2 == 0) ? 3'b001 : 3'b010;
      n_checks++;
      if (gnt !== exp) $display("FAIL contention[%0d]: got %b want %b", i, gnt, exp);
      else n_pass++;
    end
    @(negedge clk); idle();
  endtask

  task automatic test_locked_burst();
    logic [NR-1:0] exp;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); req = 3'b011; lock = 3'b001; #1;
      exp = (i == 4 || i == 9) ? 3'b010 : 3'b001;
      n_checks++;
      if (gnt !== exp) $display("FAIL burst[%0d]: got %b want %b", i, gnt, exp);
      else n_pass++;
    end
    @(negedge clk); idle();
  endtask

  task automatic test_lock_alone();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); req = 3'b001; lock = 3'b001; #1;
      n_checks++;
      if (gnt !== 3'b001) $display("FAIL lock_alone[%0d]: got %b want 001", i, gnt);
      else n_pass++;
    end
    // Count has been sitting at MAXB, so a newcomer forces rotation at once.
    @(negedge clk); req = 3'b011; lock = 3'b001; #1;
    n_checks++; if (gnt !== 3'b010) $display("FAIL lock_alone_rot: got %b want 010", gnt);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (gnt !== 3'b001) $display("FAIL lock_alone_back: got %b want 001", gnt);
    else n_pass++;
    @(negedge clk); idle();
  endtask

  task automatic test_raw();
    do_reset();
    @(negedge clk); req = 3'b001; we = 3'b001; addr[0 +: AW] = 8'h10;
    wdata[0 +: DW] = 64'h1234; #1;
    n_checks++; if (gnt !== 3'b001) $display("FAIL raw_wgnt: got %b want 001", gnt); else n_pass++;
    @(negedge clk); idle(); req = 3'b010; addr[AW +: AW] = 8'h10; #1;
    n_checks++; if (gnt !== 3'b010) $display("FAIL raw_rgnt: got %b want 010", gnt); else n_pass++;
    n_checks++; if (mem_we !== 1'b1) $display("FAIL raw_mem_we: got %b want 1", mem_we); else n_pass++;
    n_checks++; if (mem_wdata !== 64'h1234) $display("FAIL raw_wdata: got %h want 1234", mem_wdata);
    else n_pass++;
    @(negedge clk); idle(); #1;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL raw_mem_rd: got %b want 0", mem_we); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (rvalid !== 3'b010) $display("FAIL raw_rvalid: got %b want 010", rvalid);
    else n_pass++;
    n_checks++; if (rdata !== 64'h1234) $display("FAIL raw_rdata: got %h want 1234", rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    @(negedge clk); req = 3'b010; we = '0; addr[AW +: AW] = 8'h05; #1;
    n_checks++; if (gnt !== 3'b010) $display("FAIL rmr_gnt: got %b want 010", gnt); else n_pass++;
    @(negedge clk); rst = 1'b1; idle(); #1;
    n_checks++; if (mem_en !== 1'b0) $display("FAIL rmr_mem_en: got %b want 0", mem_en); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rst = 1'b0; #1;
      n_checks++;
      if (rvalid !== 3'b000) $display("FAIL rmr_rvalid[%0d]: got %b want 000", i, rvalid);
      else n_pass++;
    end
    @(negedge clk); req = 3'b111; #1;
    n_checks++; if (gnt !== 3'b001) $display("FAIL rmr_first: got %b want 001", gnt); else n_pass++;
    @(negedge clk); idle();
  endtask

  task automatic test_random();
    int g;
    logic [NR-1:0] exp_gnt, p1_rd, p2_rv;
    logic p1_v, p1_we;
    logic [AW-1:0] p1_addr, a;
    logic [DW-1:0] p1_wdata, p1_rdata, p2_rdata, exp_rdata, d;
    do_reset();
    for (int i = 0; i < 256; i++) smem[i] = mem[i];
    m_last = NR - 1; m_owner = -1; m_cnt = 0;
    p1_v = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_rd = '0; p1_rdata = '0;
    p2_rv = '0; p2_rdata = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      req = NR'($urandom_range(0, 7));
      for (int i = 0; i < NR; i++) begin
        lock[i] = ($urandom_range(0, 3) != 0);
        we[i] = $urandom_range(0, 1) == 1;
        addr[i*AW +: AW] = AW'($urandom_range(0, 7));
        wdata[i*DW +: DW] = {$urandom, $urandom};
      end
      #1;
      model_step(req, lock, g);
      exp_gnt = (g >= 0) ? (3'b001 << g) : 3'b000;
      n_checks++;
      if (gnt !== exp_gnt) $display("FAIL rnd_gnt[%0d]: got %b want %b", c, gnt, exp_gnt);
      else n_pass++;
      n_checks++;
      if (mem_en !== p1_v) $display("FAIL rnd_mem_en[%0d]: got %b want %b", c, mem_en, p1_v);
      else n_pass++;
      if (p1_v) begin
        n_checks++;
        if (mem_we !== p1_we || mem_addr !== p1_addr)
          $display("FAIL rnd_cmd[%0d]: got we=%b a=%h want we=%b a=%h", c, mem_we, mem_addr,
                   p1_we, p1_addr);
        else n_pass++;
        if (p1_we) begin
          n_checks++;
          if (mem_wdata !== p1_wdata)
            $display("FAIL rnd_wdata[%0d]: got %h want %h", c, mem_wdata, p1_wdata);
          else n_pass++;
        end
      end
      n_checks++;
      if (rvalid !== p2_rv) $display("FAIL rnd_rvalid[%0d]: got %b want %b", c, rvalid, p2_rv);
      else n_pass++;
      exp_rdata = (p2_rv != '0) ? p2_rdata : '0;
      n_checks++;
      if (rdata !== exp_rdata) $display("FAIL rnd_rdata[%0d]: got %h want %h", c, rdata, exp_rdata);
      else n_pass++;
      p2_rv = p1_rd; p2_rdata = p1_rdata;
      if (g >= 0) begin
        a = addr[g*AW +: AW]; d = wdata[g*DW +: DW];
        p1_v = 1; p1_we = we[g[1:0]]; p1_addr = a; p1_wdata = d;
        if (p1_we) begin smem[a] = d; p1_rd = '0; end
        else begin p1_rd = exp_gnt; p1_rdata = smem[a]; end
      end else begin
        p1_v = 0; p1_rd = '0;
      end
    end
    @(negedge clk); idle();
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    idle();
    test_reset();
    test_single_read();
    test_contention();
    test_locked_burst();
    test_lock_alone();
    test_raw();
    test_reset_mid_read();
    test_random();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
